// File: rtl/store_queue_drain_unit.sv
// Drains committed stores from the store queue head into the data cache, one at a time in program order.
// Latency: a commit becomes a cache write two cycles later when idle. A miss waits RETRY_DELAY cycles, then retries.
module store_queue_drain_unit #(
    parameter int ENTRY_NUM    = 16,
    parameter int ADDR_WIDTH   = 32,
    parameter int COMMIT_WIDTH = 2,
    parameter int RETRY_DELAY  = 4,
    localparam int IDX_W = $clog2(ENTRY_NUM),
    localparam int CNT_W = $clog2(ENTRY_NUM + 1),
    localparam int CMT_W = $clog2(COMMIT_WIDTH + 1),
    localparam int RTY_W = $clog2(RETRY_DELAY + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CMT_W-1:0]      commitStoreNum,
    output logic [IDX_W-1:0]      headIndex,
    input  logic [ADDR_WIDTH-3:0] sqBlockAddr,
    input  logic [3:0]            sqByteWE,
    input  logic [31:0]           sqData,
    input  logic                  sqCondEnabled,
    output logic                  dcWriteReq,
    output logic [ADDR_WIDTH-1:0] dcWriteAddr,
    output logic [31:0]           dcWriteData,
    output logic [3:0]            dcWriteByteWE,
    input  logic                  dcWriteAck,
    input  logic                  dcWriteMiss,
    output logic                  releaseValid,
    output logic [CNT_W-1:0]      pendingCount,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, RETRY_WAIT} state_t;

    state_t                  state, state_nxt;
    logic [IDX_W-1:0]        head;
    logic [CNT_W-1:0]        pending;
    logic [RTY_W-1:0]        retry_cnt, retry_nxt;
    logic [ADDR_WIDTH-3:0]   req_blk;
    logic [31:0]             req_data;
    logic [3:0]              req_we;
    logic                    latch_req;
    logic                    release_head;
    logic [CNT_W:0]          pend_sum;

    always_comb begin
        state_nxt    = state;
        retry_nxt    = retry_cnt;
        latch_req    = 1'b0;
        release_head = 1'b0;
        case (state)
            IDLE: begin
                if (pending != '0) begin
                    // A failed store-conditional frees its entry without touching the cache.
                    if (!sqCondEnabled) begin
                        release_head = 1'b1;
                    end else begin
                        latch_req = 1'b1;
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (dcWriteAck) begin
                    release_head = 1'b1;
                    state_nxt    = IDLE;
                end else if (dcWriteMiss) begin
                    retry_nxt = RTY_W'(RETRY_DELAY);
                    state_nxt = RETRY_WAIT;
                end
            end
            RETRY_WAIT: begin
                if (retry_cnt <= RTY_W'(1)) begin
                    retry_nxt = '0;
                    state_nxt = ISSUE;
                end else begin
                    retry_nxt = retry_cnt - RTY_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            head      <= '0;
            pending   <= '0;
            retry_cnt <= '0;
            req_blk   <= '0;
            req_data  <= '0;
            req_we    <= '0;
        end else begin
            state     <= state_nxt;
            retry_cnt <= retry_nxt;
            pending   <= pending + CNT_W'(commitStoreNum) - CNT_W'(release_head);
            if (release_head) begin
                head <= head + IDX_W'(1);
            end
            if (latch_req) begin
                req_blk  <= sqBlockAddr;
                req_data <= sqData;
                req_we   <= sqByteWE;
            end
        end
    end

    assign pend_sum = {1'b0, pending} + (CNT_W+1)'(commitStoreNum);

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (pend_sum <= (CNT_W+1)'(ENTRY_NUM));
            assert (!(state == ISSUE && dcWriteAck && dcWriteMiss));
        end
    end

    assign headIndex     = head;
    assign pendingCount  = pending;
    assign dcWriteReq    = (state == ISSUE);
    assign dcWriteAddr   = {req_blk, 2'b00};
    assign dcWriteData   = req_data;
    assign dcWriteByteWE = req_we;
    assign releaseValid  = release_head;
    assign busy          = (pending != '0) || (state != IDLE);

endmodule

// File: tb/tb_store_queue_drain_unit.sv
// Scoreboarded bench for store_queue_drain_unit: each committed store queues its expected release,
// and every release pulse is matched against the head of that queue.
module tb_store_queue_drain_unit;

    typedef struct packed {
        logic        cond;
        logic [29:0] blk;
        logic [31:0] data;
        logic [3:0]  we;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  commitStoreNum;
    logic [3:0]  headIndex;
    logic [29:0] sqBlockAddr;
    logic [3:0]  sqByteWE;
    logic [31:0] sqData;
    logic        sqCondEnabled;
    logic        dcWriteReq;
    logic [31:0] dcWriteAddr;
    logic [31:0] dcWriteData;
    logic [3:0]  dcWriteByteWE;
    logic        dcWriteAck;
    logic        dcWriteMiss;
    logic        releaseValid;
    logic [4:0]  pendingCount;
    logic        busy;

    logic [29:0] sq_blk  [16];
    logic [31:0] sq_data [16];
    logic [3:0]  sq_we   [16];
    logic        sq_cond [16];
    logic [3:0]  tail;
    logic [3:0]  exp_head;
    logic [4:0]  max_pend;
    entry_t      exp_q[$];
    entry_t      mon_e;
    int          vec_cnt = 0;
    int          err_cnt = 0;

    store_queue_drain_unit dut (
        .clk(clk), .rst(rst), .commitStoreNum(commitStoreNum), .headIndex(headIndex),
        .sqBlockAddr(sqBlockAddr), .sqByteWE(sqByteWE), .sqData(sqData),
        .sqCondEnabled(sqCondEnabled), .dcWriteReq(dcWriteReq), .dcWriteAddr(dcWriteAddr),
        .dcWriteData(dcWriteData), .dcWriteByteWE(dcWriteByteWE), .dcWriteAck(dcWriteAck),
        .dcWriteMiss(dcWriteMiss), .releaseValid(releaseValid), .pendingCount(pendingCount),
        .busy(busy)
    );

    always #5 clk = ~clk;

    assign sqBlockAddr   = sq_blk[headIndex];
    assign sqData        = sq_data[headIndex];
    assign sqByteWE      = sq_we[headIndex];
    assign sqCondEnabled = sq_cond[headIndex];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_store(input logic [29:0] blk, input logic [31:0] d,
                              input logic [3:0] we, input logic c);
        entry_t e;
        sq_blk[tail]  = blk;
        sq_data[tail] = d;
        sq_we[tail]   = we;
        sq_cond[tail] = c;
        e.cond = c; e.blk = blk; e.data = d; e.we = we;
        exp_q.push_back(e);
        tail = tail + 4'd1;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle;
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_busy", 32'(busy), 32'd0);
        check("drain_pending", 32'(pendingCount), 32'd0);
        check("drain_head", 32'(headIndex), 32'(exp_head));
        check("drain_sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Every release pulse must match the oldest committed store, in order.
    always @(negedge clk) begin
        if (!rst) begin
            if (pendingCount > max_pend) max_pend = pendingCount;
            if (dcWriteReq) check("rel_tracks_ack", 32'(releaseValid), 32'(dcWriteAck));
            if (releaseValid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_release", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rel_is_write", 32'(dcWriteReq), 32'(mon_e.cond));
                    if (mon_e.cond) begin
                        check("wr_addr", dcWriteAddr, {mon_e.blk, 2'b00});
                        check("wr_data", dcWriteData, mon_e.data);
                        check("wr_we", 32'(dcWriteByteWE), 32'(mon_e.we));
                    end
                    exp_head = exp_head + 4'd1;
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            sq_blk[i] = '0; sq_data[i] = '0; sq_we[i] = '0; sq_cond[i] = 1'b1;
        end
        tail = '0; exp_head = '0; max_pend = '0;
        rst = 1'b1; commitStoreNum = '0; dcWriteAck = 1'b1; dcWriteMiss = 1'b0;
        step; step;
        @(negedge clk);
        check("rst_req", 32'(dcWriteReq), 32'd0);
        check("rst_release", 32'(releaseValid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_head", 32'(headIndex), 32'd0);
        check("rst_pending", 32'(pendingCount), 32'd0);
        check("rst_addr", dcWriteAddr, 32'd0);
        check("rst_data", dcWriteData, 32'd0);
        check("rst_we", 32'(dcWriteByteWE), 32'd0);

        // Basic write: commit at cycle 0, request visible at cycle 2.
        step;
        rst = 1'b0;
        push_store(30'h100, 32'hDEADBEEF, 4'b0011, 1'b1);
        commitStoreNum = 2'd1;
        step;
        commitStoreNum = 2'd0;
        @(negedge clk);
        check("t1_req_c1", 32'(dcWriteReq), 32'd0);
        check("t1_pend_c1", 32'(pendingCount), 32'd1);
        @(negedge clk);
        check("t1_req_c2", 32'(dcWriteReq), 32'd1);
        check("t1_addr", dcWriteAddr, 32'h400);
        check("t1_we", 32'(dcWriteByteWE), 32'h3);
        check("t1_release", 32'(releaseValid), 32'd1);
        @(negedge clk);
        check("t1_head", 32'(headIndex), 32'd1);
        check("t1_pend_end", 32'(pendingCount), 32'd0);
        check("t1_req_end", 32'(dcWriteReq), 32'd0);

        // Miss then retry after RETRY_DELAY idle cycles.
        step;
        dcWriteAck = 1'b0;
        push_store(30'h2AB, 32'h12345678, 4'b1111, 1'b1);
        commitStoreNum = 2'd1;
        step;
        commitStoreNum = 2'd0;
        step;
        @(negedge clk);
        check("t2_req_first", 32'(dcWriteReq), 32'd1);
        step;
        dcWriteMiss = 1'b1;
        @(negedge clk);
        check("t2_req_miss_cyc", 32'(dcWriteReq), 32'd1);
        check("t2_no_rel_miss", 32'(releaseValid), 32'd0);
        step;
        dcWriteMiss = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("t2_req_low_%0d", k), 32'(dcWriteReq), 32'd0);
        end
        @(negedge clk);
        check("t2_req_again", 32'(dcWriteReq), 32'd1);
        check("t2_addr_again", dcWriteAddr, 32'hAAC);
        check("t2_data_again", dcWriteData, 32'h12345678);
        check("t2_we_again", 32'(dcWriteByteWE), 32'hF);
        step;
        dcWriteAck = 1'b1;
        @(negedge clk);
        check("t2_release", 32'(releaseValid), 32'd1);
        @(negedge clk);
        check("t2_single_pulse", 32'(releaseValid), 32'd0);
        check("t2_head", 32'(headIndex), 32'd2);

        // Burst: 2 commits per cycle for 8 cycles, head wraps past 15.
        step;
        max_pend = '0;
        for (int c = 0; c < 8; c++) begin
            push_store(30'h1000 + 30'(2 * c), 32'hA000_0000 + 32'(2 * c), 4'(c), 1'b1);
            push_store(30'h1001 + 30'(2 * c), 32'hA000_0001 + 32'(2 * c), 4'(15 - c), 1'b1);
            commitStoreNum = 2'd2;
            step;
        end
        commitStoreNum = 2'd0;
        wait_idle;
        check("t3_head_wrapped", 32'(headIndex), 32'd2);
        check("t3_peak_le_16", 32'(max_pend <= 5'd16), 32'd1);

        // Failed SC at head while 3 stores are pending.
        step;
        dcWriteAck = 1'b0;
        push_store(30'h3000, 32'h11111111, 4'b0001, 1'b1);
        commitStoreNum = 2'd1;
        step;
        push_store(30'h3001, 32'h22222222, 4'b0010, 1'b0);
        push_store(30'h3002, 32'h33333333, 4'b0100, 1'b1);
        commitStoreNum = 2'd2;
        step;
        push_store(30'h3003, 32'h44444444, 4'b1000, 1'b1);
        commitStoreNum = 2'd1;
        step;
        commitStoreNum = 2'd0;
        @(negedge clk);
        check("t4_pend4", 32'(pendingCount), 32'd4);
        step;
        dcWriteAck = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t4_sc_no_req", 32'(dcWriteReq), 32'd0);
        check("t4_sc_release", 32'(releaseValid), 32'd1);
        check("t4_sc_pend3", 32'(pendingCount), 32'd3);
        @(negedge clk);
        check("t4_pend2", 32'(pendingCount), 32'd2);
        check("t4_no_rel", 32'(releaseValid), 32'd0);
        wait_idle;

        // Commit and release in the same cycle keep pending unchanged.
        step;
        dcWriteAck = 1'b0;
        push_store(30'h0ABC, 32'hCAFEF00D, 4'b0110, 1'b1);
        commitStoreNum = 2'd1;
        step;
        commitStoreNum = 2'd0;
        step;
        @(negedge clk);
        check("t5_req", 32'(dcWriteReq), 32'd1);
        check("t5_pend1", 32'(pendingCount), 32'd1);
        step;
        dcWriteAck = 1'b1;
        push_store(30'h0ABD, 32'hBEEF0001, 4'b1001, 1'b1);
        commitStoreNum = 2'd1;
        @(negedge clk);
        check("t5_release", 32'(releaseValid), 32'd1);
        step;
        commitStoreNum = 2'd0;
        @(negedge clk);
        check("t5_pend_still1", 32'(pendingCount), 32'd1);
        wait_idle;

        // Reset in the middle of an outstanding write.
        step;
        dcWriteAck = 1'b0;
        push_store(30'h5000, 32'h50505050, 4'b1111, 1'b1);
        push_store(30'h5001, 32'h51515151, 4'b1111, 1'b1);
        commitStoreNum = 2'd2;
        step;
        push_store(30'h5002, 32'h52525252, 4'b1111, 1'b1);
        push_store(30'h5003, 32'h53535353, 4'b1111, 1'b1);
        commitStoreNum = 2'd2;
        step;
        push_store(30'h5004, 32'h54545454, 4'b1111, 1'b1);
        commitStoreNum = 2'd1;
        step;
        commitStoreNum = 2'd0;
        @(negedge clk);
        check("t6_pend5", 32'(pendingCount), 32'd5);
        check("t6_req_before", 32'(dcWriteReq), 32'd1);
        step;
        rst = 1'b1;
        step;
        rst = 1'b0;
        exp_q.delete();
        tail = '0;
        exp_head = '0;
        @(negedge clk);
        check("t6_req_after", 32'(dcWriteReq), 32'd0);
        check("t6_pend_after", 32'(pendingCount), 32'd0);
        check("t6_head_after", 32'(headIndex), 32'd0);
        check("t6_addr_after", dcWriteAddr, 32'd0);
        check("t6_busy_after", 32'(busy), 32'd0);

        // Normal operation resumes after reset.
        step;
        dcWriteAck = 1'b1;
        push_store(30'h0777, 32'h0BADF00D, 4'b0101, 1'b1);
        commitStoreNum = 2'd1;
        step;
        commitStoreNum = 2'd0;
        wait_idle;
        check("t7_head", 32'(headIndex), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
